// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling, registered
// one-cycle rx_valid / frame_err pulses and a held output byte.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_nxt;
    logic             rx_meta_p0, rx_sync;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       data_nxt;
    logic             rx_valid_nxt, frame_err_nxt;

    // Synchroniser stage: reset to the idle-high line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_p0 <= 1'b1;
            rx_sync    <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_sync    <= rx_meta_p0;
        end
    end

    // Receiver state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            data      <= data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_cnt_nxt   = clk_cnt + CNT_W'(1);
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        data_nxt      = data;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = 3'd0;
                if (!rx_sync) state_nxt = START;
            end
            START: begin
                // Re-check the line at mid start bit to reject short glitches
                if (clk_cnt == CNT_MID) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt        = '0;
                    shift_nxt[bit_idx] = rx_sync;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    if (rx_sync) begin
                        data_nxt     = shift;
                        rx_valid_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                clk_cnt_nxt = '0;
                if (rx_sync) state_nxt = IDLE;
            end
            default: begin
                clk_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: event-queue model of expected pulses and
// the held byte, checked every cycle, plus hand-computed timing literals.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int LAT   = 3 + (CPB - 1) / 2 + 9 * CPB;
    localparam int CPB_D = 434;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx = 1'b1;
    logic       rx_d = 1'b1;
    logic [7:0] dout, dout_d;
    logic       vld, ferr, busy;
    logic       vld_d, ferr_d, busy_d;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .data(dout),
        .rx_valid(vld), .frame_err(ferr), .rx_busy(busy)
    );

    uart_rx dut_d (
        .clk(clk), .reset_n(reset_n), .rx(rx_d), .data(dout_d),
        .rx_valid(vld_d), .frame_err(ferr_d), .rx_busy(busy_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         is_err;
        logic [7:0] b;
    } ev_t;

    ev_t        q[$];
    logic [7:0] model_data = 8'h00;
    int checks = 0, errors = 0;
    int n_valid = 0, n_ferr = 0, last_vcyc = 0, prev_vcyc = 0;
    int n_valid_d = 0, n_ferr_d = 0, vcyc_d = 0;

    // Every-cycle comparison of the small DUT against the expected-event queue
    always @(negedge clk) begin
        bit  ev_v, ev_f;
        ev_t dummy;
        ev_v = 1'b0;
        ev_f = 1'b0;
        if (q.size() > 0 && q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event due=%0d now=%0d", q[0].at, cyc);
            dummy = q.pop_front();
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            ev_v = !q[0].is_err;
            ev_f = q[0].is_err;
            if (ev_v) model_data = q[0].b;
            dummy = q.pop_front();
        end
        checks += 3;
        if (vld !== ev_v) begin
            errors++;
            $display("FAIL rx_valid cyc=%0d actual=%b required=%b", cyc, vld, ev_v);
        end
        if (ferr !== ev_f) begin
            errors++;
            $display("FAIL frame_err cyc=%0d actual=%b required=%b", cyc, ferr, ev_f);
        end
        if (dout !== model_data) begin
            errors++;
            $display("FAIL data cyc=%0d actual=%h required=%h", cyc, dout, model_data);
        end
        if (vld === 1'b1) begin
            n_valid++;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
        end
        if (ferr === 1'b1) n_ferr++;
        if (vld_d === 1'b1) begin
            n_valid_d++;
            vcyc_d = cyc;
        end
        if (ferr_d === 1'b1) n_ferr_d++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input bit sel, input int n);
        if (sel) rx_d = v;
        else     rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; e is that edge's number
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit sel, output int e);
        int  n;
        ev_t ev;
        n = sel ? CPB_D : CPB;
        e = cyc;
        if (!sel) begin
            ev.at     = cyc + 1 + LAT;
            ev.is_err = !stop_v;
            ev.b      = b;
            q.push_back(ev);
        end
        drive_bit(1'b0, sel, n);
        for (int i = 0; i < 8; i++) drive_bit(b[i], sel, n);
        drive_bit(stop_v, sel, n);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        q.delete();
        model_data = 8'h00;
        #1;
        chk("rst_now_data", {24'd0, dout}, 32'h00);
        chk("rst_now_valid", {31'd0, vld}, 32'd0);
        chk("rst_now_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_now_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1500000;
        errors++;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int         e, e2, nv, nf, nb;
        logic [7:0] b96;
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {24'd0, dout}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data_d", {24'd0, dout_d}, 32'h00);
        chk("reset_busy_d", {30'd0, vld_d, ferr_d}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Default rate: 0xA5, latency measured from the frame start edge
        send_frame(8'hA5, 1'b1, 1'b1, e);
        repeat (20) @(posedge clk);
        #1;
        chk("dflt_pulses", n_valid_d, 1);
        chk("dflt_latency", vcyc_d - e, 4126);
        chk("dflt_data", {24'd0, dout_d}, 32'hA5);
        chk("dflt_ferr", n_ferr_d, 0);

        send_frame(8'hA5, 1'b1, 1'b0, e);
        chk("small_latency", last_vcyc - e, 155);
        chk("small_data", {24'd0, dout}, 32'hA5);
        repeat (10) @(posedge clk);
        #1;

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1, 1'b0, e);
        chk("b2b_first", {24'd0, dout}, 32'h00);
        send_frame(8'hFF, 1'b1, 1'b0, e2);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_spacing", last_vcyc - prev_vcyc, 160);
        chk("b2b_second", {24'd0, dout}, 32'hFF);

        // Short low glitch: busy for MID+1 cycles, no pulse
        nv = n_valid;
        nb = 0;
        rx = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) rx = 1'b1;
            @(posedge clk);
            #1;
            if (busy) nb++;
        end
        chk("glitch_busy_cycles", nb, 8);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_no_pulse", n_valid, nv);

        // Stop bit low, line held low, then recovery with 0x5A
        nv = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0, e);
        repeat (100) @(posedge clk);
        #1;
        chk("ferr_busy_hold", {31'd0, busy}, 32'd1);
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ferr_released", {31'd0, busy}, 32'd0);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_data_kept", {24'd0, dout}, 32'hFF);
        chk("ferr_no_valid", n_valid, nv);
        send_frame(8'h5A, 1'b1, 1'b0, e);
        repeat (3) @(posedge clk);
        #1;
        chk("after_ferr_data", {24'd0, dout}, 32'h5A);

        // Reset during bit 4 of 0x96
        b96 = 8'h96;
        nv = n_valid;
        drive_bit(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b96[i], 1'b0, CPB);
        rx = b96[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        async_reset();
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_pulse", n_valid, nv);
        chk("abort_data", {24'd0, dout}, 32'h00);
        send_frame(8'h81, 1'b1, 1'b0, e);
        repeat (3) @(posedge clk);
        #1;
        chk("after_abort_data", {24'd0, dout}, 32'h81);

        // Line already low when reset releases counts as a start bit
        rx = 1'b0;
        reset_n = 1'b0;
        q.delete();
        model_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, e);
        repeat (5) @(posedge clk);
        #1;
        chk("low_at_release_data", {24'd0, dout}, 32'hC3);

        // Loopback sweep of every byte value
        nv = n_valid;
        nf = n_ferr;
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1'b0, e);
        repeat (5) @(posedge clk);
        #1;
        chk("sweep_pulses", n_valid - nv, 256);
        chk("sweep_ferr", n_ferr - nf, 0);
        chk("sweep_last", {24'd0, dout}, 32'hFF);
        chk("pending_events", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per bit (50 MHz / 115200 baud).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1 LSB first.
REQ-005 SHALL have port data  output  8  last correctly framed byte received.
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse: data updated with a new byte.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 SHALL have port rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH; clk_cnt wide enough for CLKS_PER_BIT-1; 3-bit bit_idx; 8-bit shift register.
REQ-011 IDLE: clk_cnt=0, bit_idx=0; rx_sync==0 -> START.
REQ-012 START: count clk_cnt to (CLKS_PER_BIT-1)/2 (216 at default); at that count, rx_sync==0 -> DATA with clk_cnt=0; rx_sync==1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: at clk_cnt==CLKS_PER_BIT-1, store rx_sync into shift bit bit_idx, clk_cnt=0; bit_idx 7 -> STOP, else bit_idx+1.
REQ-014 STOP: at clk_cnt==CLKS_PER_BIT-1 sample rx_sync; 1 -> data<=shift register, rx_valid=1 for one cycle, -> IDLE; 0 -> frame_err=1 for one cycle, data unchanged, -> WAIT_HIGH.
REQ-015 WAIT_HIGH: hold until rx_sync==1, then -> IDLE; no start detection while in WAIT_HIGH.
REQ-016 rx_valid and frame_err SHALL never be high in the same cycle and SHALL be low in all other cycles.
REQ-017 data SHALL hold its value between rx_valid pulses; no consumer handshake, a new byte overwrites it.
REQ-018 Latency: with N = first edge at which the first synchronizer flop captures rx low, rx_valid (or frame_err) SHALL rise at edge N+4125 at default CLKS_PER_BIT.
REQ-019 Return to IDLE at mid-stop-bit SHALL allow a back-to-back start bit immediately following the stop bit to be received without loss.
REQ-020 rx_busy SHALL be combinationally derived from state (high in START, DATA, STOP, WAIT_HIGH).

Reset
REQ-021 reset_n low SHALL asynchronously force state=IDLE, synchronizer flops=1, clk_cnt=0, bit_idx=0, shift register=0, data=8'h00, rx_valid=0, frame_err=0.
REQ-022 reset_n asserted mid-frame SHALL abort the frame with no rx_valid/frame_err; after release, reception resumes on the next start bit seen in IDLE.
REQ-023 After release, a line held low SHALL be treated as a start bit (no WAIT_HIGH after reset).

Verification
REQ-024 Frame 0xA5 at 434 clk/bit -> exactly one rx_valid pulse at N+4125, data=8'hA5, frame_err never high.
REQ-025 Frames 0x00 then 0xFF back-to-back (stop bit directly followed by start) -> two rx_valid pulses 4340 cycles apart, data 8'h00 then 8'hFF.
REQ-026 rx low for 100 cycles then high -> no pulses, rx_busy high ~218 cycles then low, state IDLE.
REQ-027 Frame 0x3C with stop bit low, line held low 2000 cycles then high -> one frame_err pulse, data keeps prior value, rx_busy high until line returns high, no spurious start; next 0x5A frame -> data=8'h5A.
REQ-028 reset_n pulsed low during bit 4 of 0x96 -> all outputs reset values immediately, no pulse; following frame 0x81 -> data=8'h81.
REQ-029 Tx loopback: uart_tx driving rx with bytes 0x00..0xFF -> 256 rx_valid pulses, each data equals sent byte, zero frame_err.
